// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serialiser state encodings.
package mmio_uart_tx_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_SHIFTING  = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;

    localparam int BAUD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A divider of zero would stall the bit timer, so it is treated as one.
    function automatic logic [BAUD_WIDTH-1:0] bit_period(input logic [BAUD_WIDTH-1:0] div);
        return (div == '0) ? BAUD_WIDTH'(1) : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output, occupancy count and
// simultaneous push/pop support (including push while full with a pop).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign count   = count_reg;
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the same edge frees a slot.
    assign push_ok = push && (!full || pop_ok);

    // Head is read combinationally so the consumer can latch it on the pop edge.
    assign head = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-path UART transmitter: register decode, TX FIFO and 8N1 serialiser
// with a programmable bit period and registered read-back.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int BAUD_DIV_RESET = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [3:0]            byte_w_en,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  tx,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            reg_sel;
    logic                  push;
    logic                  pop;
    logic                  clr_ovf;
    logic [7:0]            fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic [BAUD_WIDTH-1:0] baud_div_reg;
    logic [BAUD_WIDTH-1:0] baud_cnt_reg;
    logic                  overflow_reg;
    logic [7:0]            shift_reg;
    logic [2:0]            bit_cnt_reg;
    tx_state_t             state_reg;
    tx_state_t             state_next;
    logic                  period_end;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] r_data_reg;
    logic                  unused_ok;

    assign reg_sel   = addr[1:0];
    assign push      = byte_w_en[0] && (reg_sel == UART_TXDATA);
    assign clr_ovf   = byte_w_en[0] && (reg_sel == UART_STATUS) && w_data[3];
    assign unused_ok = ^{addr[ADDR_WIDTH-1:2], w_data[DATA_WIDTH-1:16], byte_w_en[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .w_data (w_data[7:0]),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_div_reg <= BAUD_WIDTH'(BAUD_DIV_RESET);
            overflow_reg <= 1'b0;
        end else begin
            if (byte_w_en[0] && (reg_sel == UART_BAUD)) begin
                baud_div_reg[7:0] <= w_data[7:0];
            end
            if (byte_w_en[1] && (reg_sel == UART_BAUD)) begin
                baud_div_reg[15:8] <= w_data[15:8];
            end
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Bit timer counts down to zero; the reload samples the divider only at a
    // bit boundary, so a mid-bit divider write never stretches the current bit.
    assign period_end = (baud_cnt_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (period_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (period_end && (bit_cnt_reg == 3'd7)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= '0;
        end else begin
            if (pop) begin
                shift_reg   <= fifo_head;
                bit_cnt_reg <= '0;
            end else if ((state_reg == ST_DATA) && period_end) begin
                shift_reg   <= {1'b0, shift_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if ((state_reg == ST_IDLE) || period_end) begin
                baud_cnt_reg <= bit_period(baud_div_reg) - BAUD_WIDTH'(1);
            end else begin
                baud_cnt_reg <= baud_cnt_reg - BAUD_WIDTH'(1);
            end
        end
    end

    // tx is decoded straight from state so an async reset forces it high at once.
    always_comb begin
        tx   = 1'b1;
        busy = (state_reg != ST_IDLE) || (fifo_count != '0);
        case (state_reg)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_reg[0];
            default:  tx = 1'b1;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            UART_STATUS: begin
                rd_mux[STAT_FULL]                  = fifo_full;
                rd_mux[STAT_EMPTY]                 = fifo_empty;
                rd_mux[STAT_SHIFTING]              = (state_reg != ST_IDLE);
                rd_mux[STAT_OVERFLOW]              = overflow_reg;
                rd_mux[STAT_COUNT_LSB +: CNT_W]    = fifo_count;
            end
            UART_BAUD: rd_mux[BAUD_WIDTH-1:0] = baud_div_reg;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_reg <= '0;
        end else if (r_en) begin
            r_data_reg <= rd_mux;
        end
    end

    assign r_data = r_data_reg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a serial receiver pops expected bytes
// from a scoreboard filled as bytes are pushed; register reads are checked inline.
module tb_mmio_uart_tx;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [3:0]            byte_w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  tx;
    logic                  busy;

    typedef struct {
        logic [7:0] data;
        int         period;
    } frame_t;

    frame_t     sb_q[$];
    frame_t     rx_exp;
    logic [9:0] rx_bits;
    logic       rx_glitch;
    logic       rx_on = 1'b0;
    int         frames_done = 0;
    int         last_start = 0;
    int         prev_start = 0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    mmio_uart_tx #(
        .ADDR_WIDTH     (12),
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (8),
        .BAUD_DIV_RESET (868)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .w_data    (w_data),
        .byte_w_en (byte_w_en),
        .r_en      (r_en),
        .r_data    (r_data),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=0x%0h", tag, got);
        end
    endtask

    // Receiver: samples every cycle of each bit and requires the level to stay constant.
    always begin : rx_monitor
        @(negedge clk);
        if (rx_on && tx === 1'b0) begin
            prev_start = last_start;
            last_start = cyc;
            check_eq("rx_sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                rx_exp    = sb_q.pop_front();
                rx_glitch = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int s = 0; s < rx_exp.period; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (s == 0) rx_bits[b] = tx;
                        else if (tx !== rx_bits[b]) rx_glitch = 1'b1;
                    end
                end
                check_eq("rx_data", {24'h0, rx_bits[8:1]}, {24'h0, rx_exp.data});
                check_eq("rx_framing", {29'h0, rx_glitch, rx_bits[9], rx_bits[0]}, 32'h2);
                frames_done++;
            end else begin
                while (tx === 1'b0) @(negedge clk);
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr      = {10'h1A5, a};
        w_data    = d;
        byte_w_en = be;
        @(posedge clk);
        #1 byte_w_en = 4'b0000;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = {10'h1A5, a};
        r_en = 1'b1;
        @(posedge clk);
        #1 r_en = 1'b0;
        d = r_data;
    endtask

    task automatic push_byte(input logic [7:0] b, input int p, input bit track);
        if (track) sb_q.push_back('{data: b, period: p});
        bus_write(2'd0, {24'hC3C3C3, b}, 4'b0001);
    endtask

    task automatic wait_idle(input string tag, input int budget, output int fall_cyc);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle_in_time"}, 32'(n < budget), 32'd1);
        fall_cyc = cyc;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_start_in_time"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wave;
        logic [31:0] bsy;
        logic [31:0] exp_w;
        logic [31:0] exp_b;
        logic [9:0]  lvl;
        int          dur [10];
        int          pos;
        int          bad;
        int          fall;

        rst = 1'b1; addr = '0; w_data = '0; byte_w_en = 4'b0; r_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_r_data", r_data, 32'h0);
        check_eq("reset_tx_busy", {30'h0, tx, busy}, 32'h2);
        rst = 1'b0;

        // Idle after reset
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq("idle_bad_cycles", bad, 0);
        bus_read(2'd1, rd); check_eq("status_reset", rd, 32'h2);
        bus_read(2'd2, rd); check_eq("baud_reset", rd, 32'd868);
        bus_read(2'd3, rd); check_eq("reserved_read", rd, 32'h0);

        // Single byte at divider 4
        bus_write(2'd2, 32'h0000_0004, 4'b0011);
        rx_on = 1'b1;
        push_byte(8'hA5, 4, 1'b1);
        wait_idle("single", 200, fall);
        check_eq("single_busy_len", fall - last_start, 40);
        check_eq("single_frames", frames_done, 1);

        // Back-to-back frames at divider 2
        bus_write(2'd2, 32'h0000_0002, 4'b0011);
        push_byte(8'h01, 2, 1'b1);
        push_byte(8'h80, 2, 1'b1);
        bus_read(2'd1, rd); check_eq("b2b_status_count1", rd, 32'h14);
        wait_idle("b2b", 200, fall);
        check_eq("b2b_start_gap", last_start - prev_start, 20);
        check_eq("b2b_last_len", fall - last_start, 20);
        check_eq("b2b_frames", frames_done, 3);

        // Divider 0 behaves as 1
        bus_write(2'd2, 32'h0000_0000, 4'b0011);
        push_byte(8'hFF, 1, 1'b1);
        wait_idle("div0", 100, fall);
        check_eq("div0_len", fall - last_start, 10);
        check_eq("div0_frames", frames_done, 4);

        // Divider change in the middle of a data bit
        bus_write(2'd2, 32'h0000_0004, 4'b0011);
        rx_on = 1'b0;
        push_byte(8'h55, 4, 1'b0);
        wait_start("midbaud", 50);
        wave = '0; bsy = '0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            wave[k] = tx;
            bsy[k]  = busy;
            if (k == 9) begin
                addr = {10'h1A5, 2'd2}; w_data = 32'h2; byte_w_en = 4'b0011;
            end else begin
                byte_w_en = 4'b0000;
            end
        end
        dur = '{4, 4, 4, 2, 2, 2, 2, 2, 2, 2};
        lvl = {1'b1, 8'h55, 1'b0};
        exp_w = '1; exp_b = '0; pos = 0;
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < dur[b]; s++) begin
                exp_w[pos] = lvl[b];
                exp_b[pos] = 1'b1;
                pos++;
            end
        end
        check_eq("midbaud_tx_wave", wave, exp_w);
        check_eq("midbaud_busy_wave", bsy, exp_b);

        // Overflow: one byte shifting, eight queued, one dropped
        bus_write(2'd2, 32'd1000, 4'b0011);
        push_byte(8'hF0, 1000, 1'b0);
        for (int i = 1; i < 10; i++) push_byte(8'(i), 1000, 1'b0);
        bus_read(2'd1, rd); check_eq("ovf_status", rd, 32'h8D);
        @(negedge clk);
        addr = {10'h1A5, 2'd1}; r_en = 1'b1; w_data = 32'h8; byte_w_en = 4'b0001;
        @(posedge clk);
        #1 r_en = 1'b0; byte_w_en = 4'b0000;
        check_eq("status_read_before_clear", r_data, 32'h8D);
        bus_read(2'd1, rd); check_eq("status_after_clear", rd, 32'h85);
        bus_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
        check_eq("r_data_hold", r_data, 32'h85);
        bus_read(2'd2, rd); check_eq("baud_after_reserved_write", rd, 32'd1000);

        // Async reset during a low data bit (bit0 of 8'hF0)
        repeat (1500) @(negedge clk);
        check_eq("pre_reset_tx_low", {31'h0, tx}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("async_reset_tx_busy", {30'h0, tx, busy}, 32'h2);
        check_eq("async_reset_r_data", r_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        bus_read(2'd1, rd); check_eq("status_after_reset", rd, 32'h2);
        bus_read(2'd2, rd); check_eq("baud_after_reset", rd, 32'd868);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq("idle_after_reset_bad_cycles", bad, 0);

        // Upper byte lane only
        bus_write(2'd2, 32'h0000_ABCD, 4'b0010);
        bus_read(2'd2, rd); check_eq("baud_high_lane", rd, 32'h0000_AB64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
